// File: rtl/smi_frame_arbiter_xn.sv
// smi_frame_arbiter_xn: merges NumPorts SMI flit streams into one output, whole frames at a time.
// Arbitration is round-robin (ArbMode=0) or fixed priority with port 0 highest (ArbMode=1).
//
// Ports:
//   clk        rising-edge clock
//   srstN      synchronous active-low reset
//   inReady    per-port flit valid
//   inEofc     per-port end-of-frame control, port i at [8i+7:8i]
//   inData     per-port flit data, port i at slice i
//   inStop     per-port backpressure to the sources
//   outReady   merged flit valid (2-entry output FIFO not empty)
//   outEofc    merged end-of-frame control
//   outData    merged flit data
//   outPortId  source port of the flit at the FIFO head
//   outStop    downstream backpressure
module smi_frame_arbiter_xn #(
  parameter int FlitWidth   = 8,
  parameter int NumPorts    = 4,
  parameter int PortIdWidth = 2,
  parameter int ArbMode     = 0
) (
  input  logic                            clk,
  input  logic                            srstN,
  input  logic [NumPorts-1:0]             inReady,
  input  logic [NumPorts*8-1:0]           inEofc,
  input  logic [NumPorts*FlitWidth*8-1:0] inData,
  output logic [NumPorts-1:0]             inStop,
  output logic                            outReady,
  output logic [7:0]                      outEofc,
  output logic [FlitWidth*8-1:0]          outData,
  output logic [PortIdWidth-1:0]          outPortId,
  input  logic                            outStop
);

  localparam int DataW = FlitWidth * 8;
  localparam int IdxW  = $clog2(NumPorts);

  typedef logic [IdxW-1:0] idx_t;

  typedef enum logic {
    Idle,
    Locked
  } state_t;

  typedef struct packed {
    logic [7:0]             eofc;
    logic [DataW-1:0]       data;
    logic [PortIdWidth-1:0] portId;
  } entry_t;

  state_t state;
  idx_t   grant;
  idx_t   rrPtr;

  // Output FIFO as head/tail registers; head drives the outputs directly
  // and is cleared whenever it empties so idle outputs read zero.
  entry_t head;
  entry_t tail;
  logic   headVld;
  logic   tailVld;

  idx_t   winner;
  idx_t   pIdx;
  logic   anyReq;
  logic   grantReq;
  entry_t inEntry;
  logic   push;
  logic   pop;
  logic   lastFlit;

  function automatic idx_t wrapAdd(idx_t base, int k);
    int s;
    s = int'(base) + k;
    if (s >= NumPorts) s = s - NumPorts;
    return idx_t'(s);
  endfunction

  // Winner select. Loops run downward so the last hit is the first
  // candidate in search order.
  always_comb begin
    winner = '0;
    pIdx   = '0;
    anyReq = |inReady;
    if (ArbMode == 1) begin
      for (int i = NumPorts - 1; i >= 0; i--) begin
        if (inReady[i]) winner = idx_t'(i);
      end
    end else begin
      for (int k = NumPorts - 1; k >= 0; k--) begin
        pIdx = wrapAdd(rrPtr, k);
        if (inReady[pIdx]) winner = pIdx;
      end
    end
  end

  // Granted-port flit mux.
  always_comb begin
    grantReq = 1'b0;
    inEntry  = '0;
    for (int i = 0; i < NumPorts; i++) begin
      if (grant == idx_t'(i)) begin
        grantReq     = inReady[i];
        inEntry.eofc = inEofc[8*i +: 8];
        inEntry.data = inData[DataW*i +: DataW];
      end
    end
    inEntry.portId = PortIdWidth'(grant);
  end

  // Only the granted port may be released, and only while the FIFO
  // has a free entry.
  always_comb begin
    inStop = '1;
    for (int i = 0; i < NumPorts; i++) begin
      if (state == Locked && grant == idx_t'(i) && !tailVld) begin
        inStop[i] = 1'b0;
      end
    end
  end

  assign push     = (state == Locked) && grantReq && !tailVld;
  assign pop      = headVld && !outStop;
  assign lastFlit = (inEntry.eofc != 8'h00);

  always_ff @(posedge clk) begin
    if (!srstN) begin
      state <= Idle;
      grant <= '0;
      rrPtr <= '0;
    end else begin
      unique case (state)
        Idle: begin
          if (anyReq) begin
            grant <= winner;
            state <= Locked;
          end
        end
        Locked: begin
          if (push && lastFlit) begin
            state <= Idle;
            rrPtr <= (grant == idx_t'(NumPorts - 1)) ?
                     '0 : grant + idx_t'(1);
          end
        end
      endcase
    end
  end

  // push && pop only occurs with one entry held (a full FIFO blocks
  // push), so the incoming flit simply replaces the head.
  always_ff @(posedge clk) begin
    if (!srstN) begin
      head    <= '0;
      tail    <= '0;
      headVld <= 1'b0;
      tailVld <= 1'b0;
    end else begin
      unique case (1'b1)
        push && pop: begin
          head <= inEntry;
        end
        pop && !push: begin
          if (tailVld) begin
            head    <= tail;
            tail    <= '0;
            tailVld <= 1'b0;
          end else begin
            head    <= '0;
            headVld <= 1'b0;
          end
        end
        push && !pop: begin
          if (!headVld) begin
            head    <= inEntry;
            headVld <= 1'b1;
          end else begin
            tail    <= inEntry;
            tailVld <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign outReady  = headVld;
  assign outEofc   = head.eofc;
  assign outData   = head.data;
  assign outPortId = head.portId;

endmodule

// File: tb/tb_smi_frame_arbiter_xn.sv
// tb_smi_frame_arbiter_xn: randomized frame traffic against a frame-level
// arbitration model; dut0 is round-robin, dut1 fixed priority.
module tb_smi_frame_arbiter_xn;

  localparam int NP = 4;
  localparam int FW = 8;
  localparam int DW = FW * 8;

  typedef struct packed {
    logic [7:0]    eofc;
    logic [DW-1:0] data;
  } flit_t;

  typedef struct packed {
    logic [7:0]    eofc;
    logic [DW-1:0] data;
    logic [1:0]    pid;
  } oflit_t;

  logic clk = 1'b0;
  logic srstN = 1'b0;

  logic [NP-1:0]    inReadyA[2];
  logic [NP*8-1:0]  inEofcA[2];
  logic [NP*DW-1:0] inDataA[2];
  logic [NP-1:0]    inStopA[2];
  logic             outReadyA[2];
  logic [7:0]       outEofcA[2];
  logic [DW-1:0]    outDataA[2];
  logic [1:0]       outPortIdA[2];
  logic             outStopA[2];

  flit_t  srcQ[NP][$];
  oflit_t expOut[$];
  int     frameOrder[$];
  int     modelRrA[2];
  int     nCmp;
  int     nErr;

  always #5 clk = ~clk;

  smi_frame_arbiter_xn #(
    .FlitWidth(FW), .NumPorts(NP), .PortIdWidth(2), .ArbMode(0)
  ) dut0 (
    .clk(clk), .srstN(srstN),
    .inReady(inReadyA[0]), .inEofc(inEofcA[0]), .inData(inDataA[0]),
    .inStop(inStopA[0]), .outReady(outReadyA[0]), .outEofc(outEofcA[0]),
    .outData(outDataA[0]), .outPortId(outPortIdA[0]), .outStop(outStopA[0])
  );

  smi_frame_arbiter_xn #(
    .FlitWidth(FW), .NumPorts(NP), .PortIdWidth(2), .ArbMode(1)
  ) dut1 (
    .clk(clk), .srstN(srstN),
    .inReady(inReadyA[1]), .inEofc(inEofcA[1]), .inData(inDataA[1]),
    .inStop(inStopA[1]), .outReady(outReadyA[1]), .outEofc(outEofcA[1]),
    .outData(outDataA[1]), .outPortId(outPortIdA[1]), .outStop(outStopA[1])
  );

  task automatic clear_inputs(input int d);
    inReadyA[d] = '0;
    inEofcA[d]  = '0;
    inDataA[d]  = '0;
    outStopA[d] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    srstN = 1'b0;
    clear_inputs(0);
    clear_inputs(1);
    repeat (2) @(negedge clk);
    srstN = 1'b1;
    modelRrA[0] = 0;
    modelRrA[1] = 0;
    for (int i = 0; i < NP; i++) srcQ[i].delete();
  endtask

  task automatic gen_frame(input int p, input int len);
    flit_t f;
    for (int k = 0; k < len; k++) begin
      f.data = {$urandom, $urandom};
      f.eofc = (k == len - 1) ? 8'($urandom_range(255, 1)) : 8'h00;
      srcQ[p].push_back(f);
    end
  endtask

  // Frame-level model: with every pending port requesting, each
  // arbitration picks per mode, emits the whole frame, then advances rr.
  task automatic build_expected(input int d);
    flit_t tmp[NP][$];
    flit_t f;
    int w;
    int p;
    for (int i = 0; i < NP; i++) tmp[i] = srcQ[i];
    expOut.delete();
    frameOrder.delete();
    for (int n = 0; n < 1000; n++) begin
      w = -1;
      for (int k = 0; k < NP; k++) begin
        p = (d == 1) ? k : (modelRrA[d] + k) % NP;
        if (w < 0 && tmp[p].size() > 0) w = p;
      end
      if (w < 0) break;
      frameOrder.push_back(w);
      for (int m = 0; m < 1000; m++) begin
        f = tmp[w].pop_front();
        expOut.push_back({f.eofc, f.data, 2'(w)});
        if (f.eofc != 8'h00) break;
      end
      modelRrA[d] = (w + 1) % NP;
    end
  endtask

  task automatic run_traffic(input int d, input int gapPct,
                             input int stopPct, input int stopFrom,
                             input int stopLen, input int gapAfter,
                             input int gapLen, input bit strict,
                             input string name);
    int cyc, fi, acc, occ, forced, lastOut, cur;
    bit lastEof, gap, rdy, want;
    flit_t f;
    oflit_t e, got;
    cyc = 0; fi = 0; acc = 0; occ = 0; forced = 0;
    lastOut = -1; lastEof = 1'b0;
    build_expected(d);
    while (expOut.size() > 0 && cyc < 3000) begin
      @(negedge clk);
      cur = (fi < frameOrder.size()) ? frameOrder[fi] : -1;
      for (int i = 0; i < NP; i++) begin
        gap = 1'b0;
        if (i == cur && acc > 0) begin
          if (forced > 0) begin
            gap = 1'b1;
            forced--;
          end else if ($urandom_range(99, 0) < gapPct) begin
            gap = 1'b1;
          end
        end
        rdy = (srcQ[i].size() > 0) && !gap;
        inReadyA[d][i] = rdy;
        inEofcA[d][8*i +: 8] = rdy ? srcQ[i][0].eofc : 8'h00;
        inDataA[d][DW*i +: DW] = rdy ? srcQ[i][0].data : '0;
      end
      outStopA[d] = (cyc >= stopFrom && cyc < stopFrom + stopLen) ||
                    ($urandom_range(99, 0) < stopPct);
      #1;
      nCmp++;
      if (outReadyA[d] !== (occ > 0)) begin
        nErr++;
        $display("FAIL %s outReady cyc %0d: got %b want %b",
                 name, cyc, outReadyA[d], occ > 0);
      end
      if (cur >= 0 && acc > 0) begin
        for (int j = 0; j < NP; j++) begin
          want = (j == cur) ? (occ == 2) : 1'b1;
          nCmp++;
          if (inStopA[d][j] !== want) begin
            nErr++;
            $display("FAIL %s inStop[%0d] cyc %0d: got %b want %b",
                     name, j, cyc, inStopA[d][j], want);
          end
        end
      end
      if (outReadyA[d] && !outStopA[d]) begin
        got = {outEofcA[d], outDataA[d], outPortIdA[d]};
        nCmp++;
        if (expOut.size() == 0) begin
          nErr++;
          $display("FAIL %s extra flit cyc %0d: got %h want none",
                   name, cyc, got);
        end else begin
          e = expOut.pop_front();
          if (got !== e) begin
            nErr++;
            $display("FAIL %s out flit cyc %0d: got %h want %h",
                     name, cyc, got, e);
          end
          if (strict && lastOut >= 0) begin
            nCmp++;
            if (cyc - lastOut != (lastEof ? 2 : 1)) begin
              nErr++;
              $display("FAIL %s out spacing cyc %0d: got %0d want %0d",
                       name, cyc, cyc - lastOut, lastEof ? 2 : 1);
            end
          end
          lastOut = cyc;
          lastEof = (e.eofc != 8'h00);
          occ--;
        end
      end
      for (int i = 0; i < NP; i++) begin
        if (inReadyA[d][i] && !inStopA[d][i]) begin
          nCmp++;
          if (i != cur) begin
            nErr++;
            $display("FAIL %s accept port cyc %0d: got %0d want %0d",
                     name, cyc, i, cur);
          end
          f = srcQ[i].pop_front();
          occ++;
          acc++;
          if (fi == 0 && gapLen > 0 && acc == gapAfter) forced = gapLen;
          if (f.eofc != 8'h00) begin
            fi++;
            acc = 0;
          end
        end
      end
      cyc++;
    end
    nCmp++;
    if (expOut.size() != 0) begin
      nErr++;
      $display("FAIL %s timeout: got %0d flits left want 0",
               name, expOut.size());
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      clear_inputs(d);
      #1;
      nCmp++;
      if (outReadyA[d] !== 1'b0 || inStopA[d] !== 4'hF) begin
        nErr++;
        $display("FAIL %s drain: got outReady %b inStop %b want 0 1111",
                 name, outReadyA[d], inStopA[d]);
      end
    end
  endtask

  task automatic check_reset_outputs(input int d, input string name);
    nCmp++;
    if (outReadyA[d] !== 1'b0) begin
      nErr++;
      $display("FAIL %s outReady: got %b want 0", name, outReadyA[d]);
    end
    nCmp++;
    if (outEofcA[d] !== 8'h00) begin
      nErr++;
      $display("FAIL %s outEofc: got %h want 00", name, outEofcA[d]);
    end
    nCmp++;
    if (outDataA[d] !== '0) begin
      nErr++;
      $display("FAIL %s outData: got %h want 0", name, outDataA[d]);
    end
    nCmp++;
    if (outPortIdA[d] !== 2'd0) begin
      nErr++;
      $display("FAIL %s outPortId: got %0d want 0", name, outPortIdA[d]);
    end
    nCmp++;
    if (inStopA[d] !== 4'hF) begin
      nErr++;
      $display("FAIL %s inStop: got %b want 1111", name, inStopA[d]);
    end
  endtask

  task automatic test_reset();
    srstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs(0, "reset_rr");
    check_reset_outputs(1, "reset_fp");
    @(negedge clk);
    srstN = 1'b1;
  endtask

  task automatic test_single();
    logic [DW-1:0] dat;
    dat = {$urandom, $urandom};
    do_reset();
    @(negedge clk);
    inReadyA[0][2] = 1'b1;
    inEofcA[0][23:16] = 8'd8;
    inDataA[0][2*DW +: DW] = dat;
    @(posedge clk);
    #1;
    nCmp++;
    if (inStopA[0] !== 4'b1011 || outReadyA[0] !== 1'b0) begin
      nErr++;
      $display("FAIL single grant: got inStop %b outReady %b want 1011 0",
               inStopA[0], outReadyA[0]);
    end
    @(posedge clk);
    #1;
    clear_inputs(0);
    nCmp++;
    if ({outReadyA[0], outEofcA[0], outDataA[0], outPortIdA[0]} !==
        {1'b1, 8'd8, dat, 2'd2}) begin
      nErr++;
      $display("FAIL single out: got %b %h %h %0d want 1 08 %h 2",
               outReadyA[0], outEofcA[0], outDataA[0], outPortIdA[0], dat);
    end
    nCmp++;
    if (inStopA[0] !== 4'hF) begin
      nErr++;
      $display("FAIL single idle stop: got %b want 1111", inStopA[0]);
    end
    @(posedge clk);
    #1;
    nCmp++;
    if (outReadyA[0] !== 1'b0 || outDataA[0] !== '0) begin
      nErr++;
      $display("FAIL single empty: got %b %h want 0 0",
               outReadyA[0], outDataA[0]);
    end
    modelRrA[0] = 3;
  endtask

  task automatic test_rr_after_single();
    gen_frame(0, 2);
    gen_frame(3, 2);
    run_traffic(0, 0, 0, 0, 0, 0, 0, 1'b1, "rr_after_single");
  endtask

  task automatic test_four_frames();
    do_reset();
    for (int p = 0; p < NP; p++) gen_frame(p, 3);
    run_traffic(0, 0, 0, 0, 0, 0, 0, 1'b1, "four_frames");
  endtask

  task automatic test_fixed_priority();
    do_reset();
    for (int r = 0; r < 3; r++) begin
      gen_frame(1, $urandom_range(4, 1));
      gen_frame(3, $urandom_range(4, 1));
    end
    run_traffic(1, 0, 0, 0, 0, 0, 0, 1'b1, "fixed_priority");
  endtask

  task automatic test_stop_hold();
    do_reset();
    gen_frame(2, 5);
    run_traffic(0, 0, 0, 3, 10, 0, 0, 1'b0, "stop_hold");
  endtask

  task automatic test_gap_hold();
    do_reset();
    gen_frame(0, 1);
    run_traffic(0, 0, 0, 0, 0, 0, 0, 1'b0, "gap_pre");
    gen_frame(1, 5);
    gen_frame(0, 2);
    run_traffic(0, 0, 0, 0, 0, 2, 4, 1'b0, "gap_hold");
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < NP; p++) begin
          gen_frame(p, $urandom_range(6, 1));
          gen_frame(p, $urandom_range(6, 1));
        end
        run_traffic(d, 25, 30, 0, 0, 0, 0, 1'b0,
                    d == 0 ? "random_rr" : "random_fp");
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    gen_frame(1, 1);
    run_traffic(0, 0, 0, 0, 0, 0, 0, 1'b0, "rst_pre");
    @(negedge clk);
    outStopA[0] = 1'b1;
    inReadyA[0][3] = 1'b1;
    inEofcA[0][31:24] = 8'h00;
    inDataA[0][3*DW +: DW] = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    @(negedge clk);
    srstN = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs(0, "rst_mid");
    @(negedge clk);
    srstN = 1'b1;
    clear_inputs(0);
    @(posedge clk);
    #1;
    nCmp++;
    if (outReadyA[0] !== 1'b0 || inStopA[0] !== 4'hF) begin
      nErr++;
      $display("FAIL rst_release: got outReady %b inStop %b want 0 1111",
               outReadyA[0], inStopA[0]);
    end
    modelRrA[0] = 0;
    gen_frame(1, 2);
    gen_frame(3, 2);
    run_traffic(0, 0, 0, 0, 0, 0, 0, 1'b1, "rst_post");
  endtask

  initial begin
    nCmp = 0;
    nErr = 0;
    modelRrA[0] = 0;
    modelRrA[1] = 0;
    clear_inputs(0);
    clear_inputs(1);
    test_reset();
    test_single();
    test_rr_after_single();
    test_four_frames();
    test_fixed_priority();
    test_stop_hold();
    test_gap_hold();
    test_random();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/smi_frame_arbiter_xn.md
SMI_FRAME_ARBITER_XN -- requirements
Module: smi_frame_arbiter_xn

Interface
REQ-001 SHALL have parameter FlitWidth, default 8, data bytes per flit (8..64, power of 2).
REQ-002 SHALL have parameter NumPorts, default 4, number of SMI input ports (2..8).
REQ-003 SHALL have parameter PortIdWidth, default 2, width of outPortId (>= clog2(NumPorts)).
REQ-004 SHALL have parameter ArbMode, default 0, 0 = round-robin, 1 = fixed priority (port 0 highest).
REQ-005 SHALL provide clk  input  1  sole clock, all logic rising-edge.
REQ-006 SHALL provide srstN  input  1  reset; one clock, reset is synchronous and active-low.
REQ-007 SHALL provide inReady  input  NumPorts  per-port flit valid.
REQ-008 SHALL provide inEofc  input  NumPorts*8  per-port end-of-frame control, port i at [8i+7:8i].
REQ-009 SHALL provide inData  input  NumPorts*FlitWidth*8  per-port flit data, port i at slice i.
REQ-010 SHALL provide inStop  output  NumPorts  per-port backpressure.
REQ-011 SHALL provide outReady  output  1  merged flit valid.
REQ-012 SHALL provide outEofc  output  8  merged end-of-frame control.
REQ-013 SHALL provide outData  output  FlitWidth*8  merged flit data.
REQ-014 SHALL provide outPortId  output  PortIdWidth  source port of current output flit.
REQ-015 SHALL provide outStop  input  1  downstream backpressure.

Function
REQ-016 A flit SHALL transfer on port i when inReady[i]=1 and inStop[i]=0 at a clock edge; on output when outReady=1 and outStop=0.
REQ-017 A frame SHALL end at the flit with eofc != 0; eofc = 0 means mid-frame.
REQ-018 FSM SHALL have states IDLE and LOCKED, plus registered grant index.
REQ-019 In IDLE with any inReady set: select winner, register grant, go LOCKED next cycle; no flit accepted in IDLE.
REQ-020 ArbMode=0: winner = first requesting port searching upward from rrPtr, wrapping NumPorts-1 -> 0.
REQ-021 ArbMode=1: winner = lowest-index requesting port; rrPtr ignored.
REQ-022 In LOCKED, only the granted port SHALL have inStop=0 (when buffer has space); all others inStop=1.
REQ-023 Grant SHALL hold for the whole frame regardless of granted inReady gaps or other requests.
REQ-024 On accepting granted flit with eofc != 0: go IDLE next cycle; rrPtr <= (grant+1) mod NumPorts.
REQ-025 Output SHALL be a 2-entry FIFO of {eofc, data, portId}; inStop[grant]=1 when FIFO holds 2 entries.
REQ-026 Flit accepted at cycle t SHALL appear on output at t+1 if FIFO empty and no outStop; order preserved.
REQ-027 Simultaneous push and pop with FIFO full SHALL NOT occur (full blocks push); push+pop at 1 entry keeps count 1.
REQ-028 outEofc, outData, outPortId SHALL be driven from FIFO head only; zero when empty.
REQ-029 Throughput SHALL be 1 flit/cycle within a frame; one IDLE bubble cycle between frames.
REQ-030 outStop held indefinitely SHALL cause no loss, duplication or reordering.
REQ-031 Data and eofc SHALL pass unmodified; no frame content inspection other than eofc != 0.

Reset
REQ-032 While srstN=0 at clk edge: state IDLE, grant 0, rrPtr 0, FIFO empty, outReady 0, outEofc 0, outData 0, outPortId 0, inStop all 1.
REQ-033 Reset mid-frame SHALL discard the partial frame and FIFO contents; no flit output in the cycle after srstN rises.

Verification
REQ-034 NumPorts=4, ArbMode=0, ports 0..3 each request one 3-flit frame at once -> output frames in order 0,1,2,3, each contiguous, outPortId matching, 1 bubble between.
REQ-035 Port 2 single-flit frame (eofc=8) into idle arbiter -> grant cycle t, accept t+1, outReady at t+2, rrPtr becomes 3.
REQ-036 ArbMode=1, ports 1 and 3 always requesting -> port 1 wins every arbitration; port 3 never granted.
REQ-037 outStop=1 for 10 cycles mid 5-flit frame -> inStop[grant]=1 after 2 flits buffered; all 5 flits delivered once, in order.
REQ-038 Granted port drops inReady for 4 cycles mid-frame while port 0 requests -> grant held, port 0 inStop=1 until frame end.
REQ-039 srstN=0 for 1 cycle during frame -> all outputs reset values, inStop all 1; next frame arbitrates from rrPtr 0.
